// File: rtl/sm2201_pkg.sv
// Shared types and timing defaults for the ISA-to-CAMAC cycle sequencer.
package sm2201_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_S1,
    ST_GAP,
    ST_S2,
    ST_DONE,
    ST_TOUT
  } seq_state_t;

  localparam int DEF_S1_CYCLES      = 2;
  localparam int DEF_GAP_CYCLES     = 1;
  localparam int DEF_S2_CYCLES      = 2;
  localparam int DEF_TIMEOUT_CYCLES = 255;

  // Bits needed to hold the largest of the four cycle counts.
  function automatic int clog2_max(input int p0, input int p1, input int p2, input int p3);
    int m;
    m = p0;
    if (p1 > m) m = p1;
    if (p2 > m) m = p2;
    if (p3 > m) m = p3;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/seq_down_counter.sv
// Loadable down-counter that stops at zero; reused for every timed phase.
module seq_down_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             zero
);

  // Load has priority; decrement saturates at zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/camac_cycle_sequencer.sv
// Turns one ISA access (sel/tim) into a CAMAC S1/S2 strobe cycle with
// optional X-response wait, timeout, completion interrupt and status.
module camac_cycle_sequencer
  import sm2201_pkg::*;
#(
  parameter int ADDR_W         = 2,
  parameter int S1_CYCLES      = DEF_S1_CYCLES,
  parameter int GAP_CYCLES     = DEF_GAP_CYCLES,
  parameter int S2_CYCLES      = DEF_S2_CYCLES,
  parameter int WAIT_X         = 0,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int CNT_W          = clog2_max(S1_CYCLES, GAP_CYCLES, S2_CYCLES, TIMEOUT_CYCLES)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] a,
  input  logic              w,
  input  logic              sel,
  input  logic              tim,
  input  logic              ie,
  input  logic              cx1,
  output logic              rdy,
  output logic              c1,
  output logic              c2,
  output logic              sel2,
  output logic              x0,
  output logic              x1,
  output logic              irq,
  output logic              tout,
  output logic [ADDR_W-1:0] a_q,
  output logic              w_q
);

  // In X-wait mode the counter spans the whole timeout window and the
  // minimum S1 length is detected by comparing against a threshold.
  localparam int               S1_LOAD_I = (WAIT_X != 0) ? TIMEOUT_CYCLES - 1 : S1_CYCLES - 1;
  localparam logic [CNT_W-1:0] S1_LOAD   = CNT_W'(S1_LOAD_I);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] S2_LOAD   = CNT_W'(S2_CYCLES - 1);
  localparam int               MIN_THR   = TIMEOUT_CYCLES - S1_CYCLES;

  seq_state_t       state, state_nx;
  logic             cnt_load, cnt_dec, cnt_zero;
  logic [CNT_W-1:0] cnt_val, cnt;
  logic             start, s1_min_ok, s1_done, s1_tout, entry_q;

  seq_down_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .cnt      (cnt),
    .zero     (cnt_zero)
  );

  assign start     = (state == ST_IDLE) && !sel && !tim;
  assign s1_min_ok = (MIN_THR >= 0) && (int'(cnt) <= MIN_THR);
  // X wins over timeout when both happen on the same cycle.
  assign s1_done   = (state == ST_S1) && ((WAIT_X == 0) ? cnt_zero : (s1_min_ok && cx1));
  assign s1_tout   = (state == ST_S1) && (WAIT_X != 0) && cnt_zero && !(s1_min_ok && cx1);

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nx;
  end

  // Next-state and counter control.
  always_comb begin
    state_nx = state;
    cnt_load = 1'b0;
    cnt_val  = '0;
    cnt_dec  = 1'b0;
    case (state)
      ST_IDLE:  if (start) state_nx = ST_SETUP;
      ST_SETUP: begin
        state_nx = ST_S1;
        cnt_load = 1'b1;
        cnt_val  = S1_LOAD;
      end
      ST_S1: begin
        cnt_dec = 1'b1;
        if (s1_done) begin
          cnt_load = 1'b1;
          if (GAP_CYCLES > 0) begin
            state_nx = ST_GAP;
            cnt_val  = GAP_LOAD;
          end else begin
            state_nx = ST_S2;
            cnt_val  = S2_LOAD;
          end
        end else if (s1_tout) begin
          state_nx = ST_TOUT;
        end
      end
      ST_GAP: begin
        cnt_dec = 1'b1;
        if (cnt_zero) begin
          state_nx = ST_S2;
          cnt_load = 1'b1;
          cnt_val  = S2_LOAD;
        end
      end
      ST_S2: begin
        cnt_dec = 1'b1;
        if (cnt_zero) state_nx = ST_DONE;
      end
      ST_DONE, ST_TOUT: if (sel) state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // Marks the first cycle spent in DONE/TOUT so irq fires exactly once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) entry_q <= 1'b0;
    else          entry_q <= (state_nx != state) && (state_nx inside {ST_DONE, ST_TOUT});
  end

  // Registered outputs: strobes follow the state one cycle later; status is sticky per access.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdy  <= 1'b1;
      c1   <= 1'b0;
      c2   <= 1'b0;
      sel2 <= 1'b0;
      irq  <= 1'b0;
      x0   <= 1'b0;
      x1   <= 1'b0;
      tout <= 1'b0;
      a_q  <= '0;
      w_q  <= 1'b0;
    end else begin
      rdy  <= state inside {ST_IDLE, ST_DONE, ST_TOUT};
      c1   <= (state == ST_S1);
      c2   <= (state == ST_S2);
      sel2 <= state inside {ST_SETUP, ST_S1, ST_GAP, ST_S2};
      irq  <= entry_q && ie;
      if (start) begin
        a_q  <= a;
        w_q  <= w;
        x0   <= 1'b0;
        x1   <= 1'b0;
        tout <= 1'b0;
      end else if (s1_done) begin
        x1 <= cx1;
        x0 <= ~cx1;
      end else if (state == ST_TOUT) begin
        tout <= 1'b1;
        x0   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_camac_cycle_sequencer.sv
// Bench for camac_cycle_sequencer: one default instance and one X-wait
// instance (TIMEOUT_CYCLES=8) share stimulus; per-access results are
// scoreboarded against a small behavioural model.
module tb_camac_cycle_sequencer;

  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [AW-1:0] a;
  logic          w, sel, tim, ie, cx1;
  wire  [1:0]    rdy_w, c1_w, c2_w, sel2_w, x0_w, x1_w, irq_w, tout_w, wq_w;
  wire  [AW-1:0] aq0, aq1;

  always #5 clk = ~clk;

  camac_cycle_sequencer dut0 (
    .clk(clk), .reset_n(reset_n), .a(a), .w(w), .sel(sel), .tim(tim), .ie(ie), .cx1(cx1),
    .rdy(rdy_w[0]), .c1(c1_w[0]), .c2(c2_w[0]), .sel2(sel2_w[0]), .x0(x0_w[0]), .x1(x1_w[0]),
    .irq(irq_w[0]), .tout(tout_w[0]), .a_q(aq0), .w_q(wq_w[0])
  );

  camac_cycle_sequencer #(.WAIT_X(1), .TIMEOUT_CYCLES(8)) dut1 (
    .clk(clk), .reset_n(reset_n), .a(a), .w(w), .sel(sel), .tim(tim), .ie(ie), .cx1(cx1),
    .rdy(rdy_w[1]), .c1(c1_w[1]), .c2(c2_w[1]), .sel2(sel2_w[1]), .x0(x0_w[1]), .x1(x1_w[1]),
    .irq(irq_w[1]), .tout(tout_w[1]), .a_q(aq1), .w_q(wq_w[1])
  );

  typedef enum int {CX_HI, CX_LO, CX_LATE} cx_mode_t;

  typedef struct {
    int            low, c1, c2, sel2, c1_first, irq, ovl;
    logic          x0, x1, tout, wq;
    logic [AW-1:0] aq;
  } obs_t;

  typedef struct {
    logic [AW-1:0] a;
    logic          w, ie;
    cx_mode_t      mode;
    bit            sel_early;
    obs_t          exp0, exp1;
  } vec_t;

  typedef struct {
    int   idx;
    obs_t e;
  } pend_t;

  int    total = 0;
  int    bad   = 0;
  bit    mon_en = 1'b0;
  pend_t q0[$];
  pend_t q1[$];
  obs_t  cur[2];
  bit    busy[2];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic obs_t obs_zero();
    obs_t o;
    o.low = 0; o.c1 = 0; o.c2 = 0; o.sel2 = 0; o.c1_first = -1; o.irq = 0; o.ovl = 0;
    o.x0 = 1'b0; o.x1 = 1'b0; o.tout = 1'b0; o.wq = 1'b0; o.aq = '0;
    return o;
  endfunction

  // Behavioural expectation: S1=2, GAP=1, S2=2; dut1 waits for X up to 8 S1 cycles,
  // CX_LATE raises cx1 so that it is first seen on the 6th S1 cycle.
  function automatic obs_t model(input int d, input vec_t v);
    obs_t e;
    int s1, gp, s2;
    s1 = 2; gp = 1; s2 = 2;
    e = obs_zero();
    e.c1_first = 1;
    e.irq = v.ie ? 1 : 0;
    e.aq  = v.a;
    e.wq  = v.w;
    if (d == 0 || v.mode == CX_HI) begin
      e.c1 = s1; e.x1 = (v.mode == CX_HI); e.c2 = s2;
    end else if (v.mode == CX_LATE) begin
      e.c1 = 6; e.x1 = 1'b1; e.c2 = s2;
    end else begin
      e.c1 = 8; e.x1 = 1'b0; e.c2 = 0; e.tout = 1'b1;
    end
    e.x0   = !e.x1;
    e.low  = 1 + e.c1 + (e.tout ? 0 : gp + s2);
    e.sel2 = e.low;
    return e;
  endfunction

  function automatic vec_t mk(input logic [AW-1:0] va, input logic vw, input logic vie,
                              input cx_mode_t m, input bit se);
    vec_t v;
    v.a = va; v.w = vw; v.ie = vie; v.mode = m; v.sel_early = se;
    v.exp0 = model(0, v);
    v.exp1 = model(1, v);
    return v;
  endfunction

  task automatic cmp_obs(input int d, input int idx, input obs_t g, input obs_t e);
    string p;
    p = $sformatf("v%0d.dut%0d", idx, d);
    check({p, ".rdy_low"},  g.low,      e.low);
    check({p, ".c1_len"},   g.c1,       e.c1);
    check({p, ".c2_len"},   g.c2,       e.c2);
    check({p, ".sel2_len"}, g.sel2,     e.sel2);
    check({p, ".c1_first"}, g.c1_first, e.c1_first);
    check({p, ".irq_cnt"},  g.irq,      e.irq);
    check({p, ".c1c2_ovl"}, g.ovl,      e.ovl);
    check({p, ".x0"},       g.x0,       e.x0);
    check({p, ".x1"},       g.x1,       e.x1);
    check({p, ".tout"},     g.tout,     e.tout);
    check({p, ".a_q"},      g.aq,       e.aq);
    check({p, ".w_q"},      g.wq,       e.wq);
  endtask

  // Monitor: measures each access from rdy falling to rdy rising, then scores it.
  initial forever begin
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      if (!mon_en || !reset_n) begin
        busy[d] = 1'b0;
        cur[d]  = obs_zero();
      end else begin
        if (irq_w[d]) cur[d].irq++;
        if (c1_w[d] && c2_w[d]) cur[d].ovl++;
        if (!rdy_w[d]) begin
          busy[d] = 1'b1;
          if (c1_w[d]) begin
            if (cur[d].c1 == 0) cur[d].c1_first = cur[d].low;
            cur[d].c1++;
          end
          if (c2_w[d]) cur[d].c2++;
          if (sel2_w[d]) cur[d].sel2++;
          cur[d].low++;
        end else if (busy[d]) begin
          busy[d]     = 1'b0;
          cur[d].x0   = x0_w[d];
          cur[d].x1   = x1_w[d];
          cur[d].tout = tout_w[d];
          cur[d].wq   = wq_w[d];
          cur[d].aq   = (d == 0) ? aq0 : aq1;
          if (((d == 0) ? q0.size() : q1.size()) == 0) begin
            total++; bad++;
            $display("FAIL dut%0d.unexpected_access: got completion expected none", d);
          end else begin
            pend_t pp;
            pp = (d == 0) ? q0.pop_front() : q1.pop_front();
            cmp_obs(d, pp.idx, cur[d], pp.e);
          end
          cur[d] = obs_zero();
        end
      end
    end
  end

  initial begin
    vec_t  tbl[6];
    pend_t pp;
    int    n, lowcnt, irqcnt;

    reset_n = 1'b0; a = '0; w = 1'b0; sel = 1'b1; tim = 1'b1; ie = 1'b0; cx1 = 1'b0;

    tbl[0] = mk(2'd2, 1'b1, 1'b1, CX_HI,   1'b0);
    tbl[1] = mk(2'd1, 1'b0, 1'b1, CX_LO,   1'b0);
    tbl[2] = mk(2'd3, 1'b1, 1'b1, CX_LATE, 1'b0);
    tbl[3] = mk(2'd0, 1'b1, 1'b0, CX_LO,   1'b1);
    tbl[4] = mk(2'd1, 1'b0, 1'b0, CX_HI,   1'b1);
    tbl[5] = mk(2'd2, 1'b0, 1'b0, CX_LATE, 1'b0);

    // Reset values
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("reset.rdy%0d", d),  rdy_w[d],  1);
      check($sformatf("reset.c1_%0d", d),  c1_w[d],   0);
      check($sformatf("reset.c2_%0d", d),  c2_w[d],   0);
      check($sformatf("reset.sel2%0d", d), sel2_w[d], 0);
      check($sformatf("reset.x0_%0d", d),  x0_w[d],   0);
      check($sformatf("reset.x1_%0d", d),  x1_w[d],   0);
      check($sformatf("reset.irq%0d", d),  irq_w[d],  0);
      check($sformatf("reset.tout%0d", d), tout_w[d], 0);
      check($sformatf("reset.w_q%0d", d),  wq_w[d],   0);
    end
    check("reset.a_q0", aq0, 0);
    check("reset.a_q1", aq1, 0);
    reset_n = 1'b1;

    // Asynchronous reset in the middle of S1
    @(negedge clk); a = 2'd3; w = 1'b1; cx1 = 1'b1; sel = 1'b0; tim = 1'b0;
    @(negedge clk); tim = 1'b1;
    n = 0;
    while (!c1_w[0] && n < 10) begin @(negedge clk); n++; end
    check("midrst.c1_before", c1_w[0], 1);
    #2 reset_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("midrst.c1_%0d", d),   c1_w[d],   0);
      check($sformatf("midrst.rdy%0d", d),   rdy_w[d],  1);
      check($sformatf("midrst.sel2%0d", d),  sel2_w[d], 0);
    end
    check("midrst.a_q0", aq0, 0);
    sel = 1'b1;
    @(negedge clk); reset_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("midrst.idle_rdy", rdy_w[0], 1);
      check("midrst.idle_c1",  c1_w[0],  0);
    end

    // Handshake: held sel/tim must not retrigger, a sel=1 pulse re-arms
    @(negedge clk); a = 2'd1; w = 1'b0; ie = 1'b1; cx1 = 1'b1; sel = 1'b0; tim = 1'b0;
    @(negedge clk); check("hs.rdy_1cyc", rdy_w[0], 1);
    @(negedge clk); check("hs.rdy_2cyc", rdy_w[0], 0);
    check("hs.c1_2cyc", c1_w[0], 0);
    @(negedge clk); check("hs.c1_3cyc", c1_w[0], 1);
    n = 0;
    while (!(rdy_w[0] && rdy_w[1]) && n < 30) begin @(negedge clk); n++; end
    check("hs.done_reached", rdy_w[0] & rdy_w[1], 1);
    lowcnt = 0; irqcnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (!rdy_w[0] || !rdy_w[1]) lowcnt++;
      if (irq_w[0] || irq_w[1]) irqcnt++;
    end
    check("hs.no_retrigger", lowcnt, 0);
    check("hs.no_extra_irq", irqcnt, 0);
    sel = 1'b1;
    @(negedge clk); sel = 1'b0;
    n = 0;
    while (rdy_w[0] && n < 4) begin @(negedge clk); n++; end
    check("hs.restart", rdy_w[0], 0);
    tim = 1'b1;
    n = 0;
    while (!(rdy_w[0] && rdy_w[1]) && n < 30) begin @(negedge clk); n++; end
    check("hs.restart_done", rdy_w[0] & rdy_w[1], 1);
    sel = 1'b1;
    repeat (2) @(negedge clk);

    // Table-driven accesses, scored by the monitor
    mon_en = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      a = tbl[i].a; w = tbl[i].w; ie = tbl[i].ie; cx1 = (tbl[i].mode == CX_HI);
      sel = 1'b0; tim = 1'b0;
      pp.idx = i; pp.e = tbl[i].exp0; q0.push_back(pp);
      pp.idx = i; pp.e = tbl[i].exp1; q1.push_back(pp);
      n = 0;
      while (n < 60) begin
        @(negedge clk);
        n++;
        if (n == 1) tim = 1'b1;
        if (tbl[i].sel_early && n == 2) sel = 1'b1;
        if (tbl[i].mode == CX_LATE && n == 7) cx1 = 1'b1;
        if (n >= 3 && q0.size() == 0 && q1.size() == 0) break;
      end
      if (n >= 60) begin
        total++; bad++;
        $display("FAIL v%0d.completion: got no rdy within 60 cycles expected completion", i);
        q0.delete(); q1.delete();
      end
      sel = 1'b1; tim = 1'b1; cx1 = 1'b0;
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
    check("sb.q0_empty", q0.size(), 0);
    check("sb.q1_empty", q1.size(), 0);
    mon_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
